// File: rtl/mem_pkg.sv
// Shared definitions for the burst memory controller: default widths,
// memory depth, beat-count width and the controller state encoding.
package mem_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH      = 16;
    localparam int LEN_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_WR_FLUSH = 3'd2,
        ST_RD_ADDR  = 3'd3,
        ST_RD_CAP   = 3'd4,
        ST_RD_RSP   = 3'd5
    } state_t;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Request / write / response / memory-port bundle of the burst controller.
// "slave" is the controller view, "master" is the requester plus memory view.
interface mem_burst_ctrl_if #(
    parameter int ADDR_W = mem_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_pkg::DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  req_valid, req_wr, req_addr, req_len,
        input  wr_valid, wr_data, rsp_ready, mem_dout,
        output req_ready, wr_ready, rsp_valid, rsp_data,
        output busy, done, mem_addr, mem_din, mem_we
    );

    modport master (
        output req_valid, req_wr, req_addr, req_len,
        output wr_valid, wr_data, rsp_ready, mem_dout,
        input  req_ready, wr_ready, rsp_valid, rsp_data,
        input  busy, done, mem_addr, mem_din, mem_we
    );

endinterface

// File: rtl/burst_ctr.sv
// Address and beat counter of one burst: loaded with start address and
// length, advanced once per beat; address wraps modulo 2^ADDR_W.
module burst_ctr
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_cur,
    output logic [ADDR_W-1:0] o_next,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_cur;
    logic [LEN_W-1:0]  r_remain;

    // Load on request accept, otherwise step address and count down remaining beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur    <= '0;
            r_remain <= '0;
        end else if (i_load) begin
            r_cur    <= i_start;
            r_remain <= i_len;
        end else if (i_inc) begin
            r_cur <= r_cur + ADDR_W'(1);
            if (r_remain != LEN_W'(0)) begin
                r_remain <= r_remain - LEN_W'(1);
            end
        end
    end

    assign o_cur  = r_cur;
    assign o_next = r_cur + ADDR_W'(1);
    assign o_last = (r_remain == LEN_W'(0));

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller in front of a single-port synchronous memory. Write
// bursts stream beats straight to the memory port; read bursts run one
// address/capture/response round per beat with a held response handshake.
module mem_burst_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mem_burst_ctrl_if.slave bus
);

    state_t            r_state;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_valid;
    logic              r_done;

    logic              w_accept;
    logic              w_wr_beat;
    logic              w_consume;
    logic              w_inc;
    logic [ADDR_W-1:0] w_cur;
    logic [ADDR_W-1:0] w_next;
    logic              w_last;

    assign w_accept  = bus.req_valid && (r_state == ST_IDLE);
    assign w_wr_beat = bus.wr_valid && (r_state == ST_WR);
    assign w_consume = bus.rsp_ready && (r_state == ST_RD_RSP);
    // The final read beat does not advance; the final write beat may (counter is reloaded next burst).
    assign w_inc     = w_wr_beat || (w_consume && !w_last);

    burst_ctr #(
        .ADDR_W (ADDR_W)
    ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_start (bus.req_addr),
        .i_len   (bus.req_len),
        .i_inc   (w_inc),
        .o_cur   (w_cur),
        .o_next  (w_next),
        .o_last  (w_last)
    );

    // Burst sequencing with registered memory port, response and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_mem_we <= 1'b0;
                    if (bus.req_valid) begin
                        if (bus.req_wr) begin
                            r_state <= ST_WR;
                        end else begin
                            r_mem_addr <= bus.req_addr;
                            r_state    <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR: begin
                    if (bus.wr_valid) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_cur;
                        r_mem_din  <= bus.wr_data;
                        if (w_last) begin
                            r_state <= ST_WR_FLUSH;
                        end
                    end else begin
                        r_mem_we <= 1'b0;
                    end
                end
                ST_WR_FLUSH: begin
                    // Final beat is written at this edge.
                    r_mem_we <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                ST_RD_ADDR: begin
                    // Memory samples mem_addr at this edge.
                    r_mem_we <= 1'b0;
                    r_state  <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    r_mem_we    <= 1'b0;
                    r_rsp_data  <= bus.mem_dout;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RD_RSP;
                end
                ST_RD_RSP: begin
                    r_mem_we <= 1'b0;
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_mem_addr <= w_next;
                            r_state    <= ST_RD_ADDR;
                        end
                    end
                end
                default: begin
                    r_mem_we    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.wr_ready  = (r_state == ST_WR);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.done      = r_done;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_din   = r_mem_din;
    assign bus.mem_we    = r_mem_we;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: directed and random bursts against
// a reference memory array, with a memory model and write-port monitor.
module tb_mem_burst_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_burst_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus();

    mem_burst_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem     [16];
    logic [7:0] ref_mem [16];
    logic [7:0] wdata   [16];
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int wlog_addr[$];
    int wlog_data[$];
    int wlog_cyc[$];

    // Memory model plus monitors of write-port activity and done pulses.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.done) done_cnt = done_cnt + 1;
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_din;
            wlog_addr.push_back(int'(bus.mem_addr));
            wlog_data.push_back(int'(bus.mem_din));
            wlog_cyc.push_back(cyc);
        end else begin
            bus.mem_dout <= mem[bus.mem_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wlog_addr.delete();
        wlog_data.delete();
        wlog_cyc.delete();
    endtask

    task automatic issue_req(input bit wr, input int a, input int l);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = 4'(a);
        bus.req_len   = 4'(l);
        check_val("req_ready_idle", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        check_val("busy_after_accept", bus.busy, 1);
    endtask

    // Compare the logged memory writes with n expected beats from address a.
    task automatic check_wlog(input int a, input int n);
        check_val("wr_count", wlog_addr.size(), n);
        for (int k = 0; k < n && k < wlog_addr.size(); k++) begin
            check_val("wr_addr", wlog_addr[k], (a + k) % 16);
            check_val("wr_data", wlog_data[k], wdata[k]);
            ref_mem[(a + k) % 16] = wdata[k];
        end
    endtask

    // Write burst of l+1 beats; rst_at >= 0 resets at the edge accepting that beat.
    task automatic write_burst(input int a, input int l, input bit bubbles, input int rst_at);
        int i;
        int guard;
        int cnt;
        int base;
        bit aborted;
        base    = done_cnt;
        i       = 0;
        guard   = 0;
        aborted = 1'b0;
        clear_log();
        issue_req(1'b1, a, l);
        while (i <= l && guard < 200) begin
            bus.wr_valid = (bubbles && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            bus.wr_data  = wdata[i];
            check_val("wr_ready", bus.wr_ready, 1);
            if (i == rst_at && bus.wr_valid) begin
                rst = 1'b1;
                tick();
                aborted = 1'b1;
                break;
            end
            tick();
            if (bus.wr_valid) i++;
            guard++;
        end
        bus.wr_valid = 1'b0;
        if (aborted) begin
            check_val("rst_mem_we", bus.mem_we, 0);
            check_val("rst_busy", bus.busy, 0);
            check_val("rst_done", bus.done, 0);
            check_val("rst_wr_ready", bus.wr_ready, 0);
            check_val("rst_mem_addr", bus.mem_addr, 0);
            check_val("rst_mem_din", bus.mem_din, 0);
            rst = 1'b0;
            tick();
            check_val("rst_req_ready", bus.req_ready, 1);
            check_val("rst_no_done", bus.done, 0);
            tick();
            check_val("rst_done_cnt", done_cnt - base, 0);
            check_wlog(a, rst_at);
        end else begin
            cnt = 0;
            while (!bus.done && cnt < 8) begin
                tick();
                cnt++;
            end
            check_val("wr_done_lat", cnt, 1);
            check_val("wr_idle_busy", bus.busy, 0);
            check_val("wr_idle_ready", bus.req_ready, 1);
            tick();
            check_val("wr_done_width", bus.done, 0);
            check_val("wr_done_cnt", done_cnt - base, 1);
            if (!bubbles && wlog_cyc.size() == l + 1)
                check_val("wr_we_span", wlog_cyc[l] - wlog_cyc[0], l);
            check_wlog(a, l + 1);
        end
    endtask

    // Collect l+1 read beats, entered right after the accept edge.
    task automatic read_beats(input int a, input int l, input int stall_beat, input int stall_n,
                              input bit rand_stall, input bit hold_req);
        int lat;
        int s;
        logic [7:0] held;
        for (int b = 0; b <= l; b++) begin
            lat = 1;
            while (!bus.rsp_valid && lat < 12) begin
                if (hold_req) check_val("req_ready_busy", bus.req_ready, 0);
                tick();
                lat++;
            end
            check_val("rd_lat", lat, 3);
            check_val("rd_data", bus.rsp_data, ref_mem[(a + b) % 16]);
            check_val("rd_busy", bus.busy, 1);
            s = (b == stall_beat) ? stall_n : (rand_stall ? int'($urandom_range(0, 2)) : 0);
            held = bus.rsp_data;
            for (int k = 0; k < s; k++) begin
                tick();
                check_val("rd_hold_valid", bus.rsp_valid, 1);
                check_val("rd_hold_data", bus.rsp_data, held);
            end
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            check_val("rd_valid_drop", bus.rsp_valid, 0);
            if (b == l) begin
                check_val("rd_done", bus.done, 1);
                check_val("rd_idle_busy", bus.busy, 0);
                check_val("rd_idle_ready", bus.req_ready, 1);
            end else begin
                check_val("rd_no_done", bus.done, 0);
            end
        end
    endtask

    task automatic read_burst(input int a, input int l, input int stall_beat, input int stall_n,
                              input bit rand_stall);
        int base;
        base = done_cnt;
        clear_log();
        issue_req(1'b0, a, l);
        read_beats(a, l, stall_beat, stall_n, rand_stall, 1'b0);
        tick();
        check_val("rd_done_width", bus.done, 0);
        check_val("rd_done_cnt", done_cnt - base, 1);
        check_val("rd_no_we", wlog_addr.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int a;
        int l;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 4'd0;
        bus.req_len   = 4'd0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'd0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check_val("reset_mem_we", bus.mem_we, 0);
        check_val("reset_rsp_valid", bus.rsp_valid, 0);
        check_val("reset_done", bus.done, 0);
        check_val("reset_busy", bus.busy, 0);
        check_val("reset_wr_ready", bus.wr_ready, 0);
        check_val("reset_mem_addr", bus.mem_addr, 0);
        check_val("reset_mem_din", bus.mem_din, 0);
        check_val("reset_rsp_data", bus.rsp_data, 0);
        rst = 1'b0;
        tick();
        check_val("reset_req_ready", bus.req_ready, 1);

        // 4-beat write then read back at address 2
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
        write_burst(2, 3, 1'b0, -1);
        read_burst(2, 3, -1, 0, 1'b0);

        // wrap-around write at 14
        for (int i = 0; i < 4; i++) wdata[i] = 8'hA0 + 8'(i);
        write_burst(14, 3, 1'b0, -1);
        read_burst(14, 3, -1, 0, 1'b0);

        // consumer stall of 5 cycles on beat 2
        read_burst(0, 7, 1, 5, 1'b0);

        // full 16-beat burst with bubbles, then read with random stalls
        for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
        write_burst(5, 15, 1'b1, -1);
        read_burst(5, 15, -1, 0, 1'b1);

        // reset during beat 3 of an 8-beat write, then verify whole memory
        for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
        write_burst(6, 7, 1'b0, 2);
        read_burst(0, 15, -1, 0, 1'b0);

        // request held during a busy read is taken on the first IDLE cycle
        base = done_cnt;
        clear_log();
        issue_req(1'b0, 3, 2);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 4'd9;
        bus.req_len   = 4'd0;
        read_beats(3, 2, -1, 0, 1'b0, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        check_val("req2_accepted", bus.busy, 1);
        read_beats(9, 0, -1, 0, 1'b0, 1'b0);
        tick();
        check_val("req2_done_cnt", done_cnt - base, 2);

        // random traffic
        for (int n = 0; n < 14; n++) begin
            a = int'($urandom_range(0, 15));
            l = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
                write_burst(a, l, 1'($urandom_range(0, 1)), -1);
            end else begin
                read_burst(a, l, int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1'b1);
            end
        end
        read_burst(0, 15, -1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width (16 locations).
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Port list, one clock; reset synchronous, active-high:
- clk  in  1  sole clock; all state changes on its rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  burst request offered
- req_ready  out  1  controller accepts a request
- req_wr  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  burst start address
- req_len  in  4  beat count minus 1 (1..16 beats)
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted
- wr_data  in  DATA_W  write beat data
- rsp_valid  out  1  read beat valid
- rsp_ready  in  1  read beat consumed
- rsp_data  out  DATA_W  read beat data
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end
- mem_addr  out  ADDR_W  to memory addr, registered
- mem_din  out  DATA_W  to memory din, registered
- mem_we  out  1  to memory we, registered
- mem_dout  in  DATA_W  from memory dout; updated at the edge where mem_we=0

Function
REQ-004 States: IDLE, WR, WR_FLUSH, RD_ADDR, RD_CAP, RD_RSP.
REQ-005 req_ready=1 only in IDLE; request accepted on an edge with req_valid&&req_ready; start address/length latched; next state WR if req_wr else RD_ADDR.
REQ-006 busy=1 in every state except IDLE; requests offered while busy are ignored and not queued.
REQ-007 WR: wr_ready=1; per accepted beat, mem_we<=1, mem_addr<=cur, mem_din<=wr_data, cur<=cur+1; edges with no beat set mem_we<=0 (bubbles allowed).
REQ-008 After the final beat is accepted, state WR_FLUSH for exactly one cycle (final write lands); on exit mem_we<=0, done pulses, state IDLE.
REQ-009 Read, per beat: accept/RD_RSP edge drives mem_addr<=cur, mem_we<=0 -> RD_ADDR; next edge memory samples -> RD_CAP; next edge rsp_data<=mem_dout, rsp_valid<=1 -> RD_RSP.
REQ-010 Read latency: rsp_valid rises 3 clock edges after request acceptance, and 3 edges after each consumed non-final beat.
REQ-011 RD_RSP: rsp_valid and rsp_data held stable until rsp_ready; on consumption, final beat -> rsp_valid<=0, done pulse, IDLE; otherwise cur<=cur+1, mem_addr<=cur+1 -> RD_ADDR.
REQ-012 Address arithmetic modulo 2^ADDR_W: 15+1 wraps to 0, no error.
REQ-013 req_len=15 is a 16-beat burst covering every location exactly once.
REQ-014 mem_we=1 only in the cycle following an accepted write beat; never in read states.
REQ-015 done is high for exactly one cycle per completed burst, coincident with re-entering IDLE.

Reset
REQ-016 At an edge with rst=1: state IDLE; mem_we, rsp_valid, done, busy, wr_ready = 0; mem_addr, mem_din, rsp_data, counters = 0; req_ready=1 after reset release.
REQ-017 Reset mid-burst aborts it with no done pulse; mem_we drops at that edge, so no further write occurs; memory contents are not cleared.

Structure
REQ-018 Shared package mem_pkg holds the state encoding, ADDR_W/DATA_W defaults and DEPTH=16.
REQ-019 One sub-module burst_ctr holds the address and beat counter: load start/len, increment with wrap, last-beat flag.

Verification
REQ-020 Write 4 beats to addr 2 with data 0x11,0x22,0x33,0x44, wr_valid held high -> mem_we high 4 consecutive cycles at addr 2..5, WR_FLUSH, then a single done pulse.
REQ-021 Read 4 beats from addr 2, rsp_ready=1 -> rsp_data 0x11,0x22,0x33,0x44, each rsp_valid 3 edges after the previous consume, then done.
REQ-022 Write at addr 14, len=3, data 0xA0..0xA3 -> locations 14,15,0,1 written; read back matches.
REQ-023 Read burst with rsp_ready low 5 cycles on beat 2 -> rsp_valid/rsp_data held stable, no beat lost or duplicated.
REQ-024 rst asserted during beat 3 of an 8-beat write -> mem_we=0 from the reset edge, no done, locations 0..1 of burst keep new data, rest unchanged.
REQ-025 req_valid held during a busy read -> req_ready=0, second request accepted only on the first IDLE cycle.
